// File: rtl/gcd_pkg.sv
// Shared definitions for the iterative GCD engine: FSM state encoding and
// algorithm-select constants.
package gcd_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        CALC   = 2'b01,
        FINISH = 2'b10
    } state_e;

    localparam logic MODE_EUCLID = 1'b0;
    localparam logic MODE_STEIN  = 1'b1;

endpackage

// File: rtl/gcd_step.sv
// One GCD iteration, purely combinational: Euclid subtraction or one step of
// binary (Stein) reduction, selected by mode.
module gcd_step
    import gcd_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int K_W   = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [K_W-1:0]   k,
    input  logic             mode,
    output logic [WIDTH-1:0] a_nxt,
    output logic [WIDTH-1:0] b_nxt,
    output logic [K_W-1:0]   k_nxt,
    output logic             eq,
    output logic [WIDTH-1:0] result
);

    logic stein;

    assign stein = (mode == MODE_STEIN);

    // NOTE: every output gets a default before the branches, so no path
    // leaves one unassigned and no latch is inferred.
    always_comb begin
        a_nxt  = a;
        b_nxt  = b;
        k_nxt  = k;
        eq     = (a == b);
        result = stein ? (a << k) : a;

        if (!eq) begin
            if (stein && !a[0] && !b[0]) begin
                a_nxt = a >> 1;
                b_nxt = b >> 1;
                k_nxt = k + K_W'(1);
            end else if (stein && !a[0]) begin
                a_nxt = a >> 1;
            end else if (stein && !b[0]) begin
                b_nxt = b >> 1;
            end else if (a > b) begin
                a_nxt = a - b;
            end else begin
                b_nxt = b - a;
            end
        end
    end

endmodule

// File: rtl/gcd_multi.sv
// Iterative GCD engine: IDLE/CALC/FINISH controller around gcd_step, with
// registered result, error flag, busy status and saturating iteration count.
module gcd_multi
    import gcd_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int ITER_W = WIDTH + 1
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              START,
    input  logic              MODE,
    input  logic [WIDTH-1:0]  A,
    input  logic [WIDTH-1:0]  B,
    output logic [WIDTH-1:0]  Y,
    output logic              DONE,
    output logic              ERROR,
    output logic              BUSY,
    output logic [ITER_W-1:0] ITER
);

    localparam int K_W = $clog2(WIDTH) + 1;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
    logic [K_W-1:0]     k_q, k_d;
    logic               mode_q, mode_d;
    logic [WIDTH-1:0]   y_q, y_d;
    logic               done_q, done_d;
    logic               error_q, error_d;
    logic               busy_q, busy_d;
    logic [ITER_W-1:0]  iter_q, iter_d;

    logic [WIDTH-1:0]   step_a, step_b, step_result;
    logic [K_W-1:0]     step_k;
    logic               step_eq;
    logic [ITER_W-1:0]  iter_inc;

    gcd_step #(.WIDTH(WIDTH), .K_W(K_W)) u_step (
        .a      (a_q),
        .b      (b_q),
        .k      (k_q),
        .mode   (mode_q),
        .a_nxt  (step_a),
        .b_nxt  (step_b),
        .k_nxt  (step_k),
        .eq     (step_eq),
        .result (step_result)
    );

    assign iter_inc = (iter_q == {ITER_W{1'b1}}) ? iter_q : iter_q + ITER_W'(1);

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        k_d     = k_q;
        mode_d  = mode_q;
        y_d     = y_q;
        error_d = error_q;
        iter_d  = iter_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (START) begin
                    a_d    = A;
                    b_d    = B;
                    mode_d = MODE;
                    k_d    = '0;
                    iter_d = '0;
                    y_d    = '0;
                    if ((A == '0) || (B == '0)) begin
                        error_d = 1'b1;
                        done_d  = 1'b1;
                        state_d = FINISH;
                    end else begin
                        error_d = 1'b0;
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                iter_d = iter_inc;
                a_d    = step_a;
                b_d    = step_b;
                k_d    = step_k;
                if (step_eq) begin
                    y_d     = step_result;
                    done_d  = 1'b1;
                    state_d = FINISH;
                end
            end
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            k_q     <= '0;
            mode_q  <= MODE_EUCLID;
            y_q     <= '0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
            busy_q  <= 1'b0;
            iter_q  <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            k_q     <= k_d;
            mode_q  <= mode_d;
            y_q     <= y_d;
            done_q  <= done_d;
            error_q <= error_d;
            busy_q  <= busy_d;
            iter_q  <= iter_d;
        end
    end

    assign Y     = y_q;
    assign DONE  = done_q;
    assign ERROR = error_q;
    assign BUSY  = busy_q;
    assign ITER  = iter_q;

endmodule

// File: tb/tb_gcd_multi.sv
// Self-checking bench for gcd_multi: an operation-level timeline model checked
// every cycle, plus directed vectors with hand-computed results.
module tb_gcd_multi;

    localparam int WIDTH  = 8;
    localparam int ITER_W = WIDTH + 1;

    logic              clk   = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              mode  = 1'b0;
    logic [WIDTH-1:0]  a     = '0;
    logic [WIDTH-1:0]  b     = '0;
    logic [WIDTH-1:0]  y;
    logic              done;
    logic              error;
    logic              busy;
    logic [ITER_W-1:0] iter;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    gcd_multi #(.WIDTH(WIDTH), .ITER_W(ITER_W)) dut (
        .CLK   (clk),
        .RST_N (rst_n),
        .START (start),
        .MODE  (mode),
        .A     (a),
        .B     (b),
        .Y     (y),
        .DONE  (done),
        .ERROR (error),
        .BUSY  (busy),
        .ITER  (iter)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // GCD by remainder; Euclid-by-subtraction iterations equal the sum of the
    // division quotients (the last subtraction that reaches a==b plus the
    // final compare cycle together account for the last quotient).
    function automatic int ref_gcd(input int x, input int z);
        int t;
        while (z != 0) begin
            t = x % z;
            x = z;
            z = t;
        end
        return x;
    endfunction

    function automatic int euclid_iters(input int x, input int z);
        int n, t;
        n = 0;
        if (x < z) begin
            t = x; x = z; z = t;
        end
        while (z != 0) begin
            n += x / z;
            t = x % z;
            x = z;
            z = t;
        end
        return n;
    endfunction

    function automatic int stein_iters(input int x, input int z);
        int n;
        n = 1;
        while (x != z) begin
            if ((x % 2 == 0) && (z % 2 == 0)) begin
                x /= 2; z /= 2;
            end else if (x % 2 == 0) x /= 2;
            else if (z % 2 == 0)     z /= 2;
            else if (x > z)          x -= z;
            else                     z -= x;
            n++;
        end
        return n;
    endfunction

    // Operation-level model: what the outputs must be on each cycle.
    bit m_busy = 0, m_done = 0, m_err = 0;
    int m_y = 0, m_iter = 0, m_rem = 0, m_pend_y = 0, m_pend_n = 0;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_busy = 0; m_done = 0; m_err = 0; m_y = 0; m_iter = 0; m_rem = 0;
        end else if (!m_busy) begin
            if (start) begin
                m_busy = 1; m_y = 0; m_iter = 0;
                if (a == 0 || b == 0) begin
                    m_err = 1; m_done = 1;
                end else begin
                    m_err    = 0;
                    m_done   = 0;
                    m_pend_y = ref_gcd(int'(a), int'(b));
                    m_pend_n = mode ? stein_iters(int'(a), int'(b)) : euclid_iters(int'(a), int'(b));
                    m_rem    = m_pend_n;
                end
            end
        end else if (m_done) begin
            m_busy = 0; m_done = 0;
        end else begin
            m_rem--;
            if (m_rem == 0) begin
                m_done = 1; m_y = m_pend_y; m_iter = m_pend_n;
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("model_done", done, m_done);
            check("model_busy", busy, m_busy);
            if (!m_busy || m_done) begin
                check("model_y", y, m_y);
                check("model_error", error, m_err);
                check("model_iter", iter, m_iter);
            end
        end
    end

    task automatic run_op(input string name, input logic m, input logic [WIDTH-1:0] av,
                          input logic [WIDTH-1:0] bv, input int exp_y, input int exp_err,
                          input int exp_iter);
        int cyc, busy_cnt;
        bit seen;
        @(negedge clk);
        mode = m; a = av; b = bv; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        busy_cnt = busy ? 1 : 0;
        seen = done;
        while (!seen && cyc < 600) begin
            @(negedge clk);
            cyc++;
            busy_cnt += busy ? 1 : 0;
            seen = done;
        end
        check({name, "_done_seen"}, seen, 1);
        check({name, "_latency"}, cyc, exp_iter);
        check({name, "_busy_cycles"}, busy_cnt, exp_err ? 1 : exp_iter + 1);
        check({name, "_y"}, y, exp_y);
        check({name, "_error"}, error, exp_err);
        check({name, "_iter"}, iter, exp_iter);
        @(negedge clk);
        check({name, "_idle_busy"}, busy, 0);
        check({name, "_hold_y"}, y, exp_y);
    endtask

    initial begin
        int cyc, pulses;
        bit seen;

        @(posedge clk);
        cmp_en = 1'b1;
        @(negedge clk);
        check("rst_y", y, 0);
        check("rst_done", done, 0);
        check("rst_error", error, 0);
        check("rst_busy", busy, 0);
        check("rst_iter", iter, 0);
        rst_n = 1'b1;

        run_op("eu_12_18", 1'b0, 8'd12, 8'd18, 6, 0, 3);
        run_op("st_12_18", 1'b1, 8'd12, 8'd18, 6, 0, 5);
        run_op("eu_0_35",  1'b0, 8'd0,  8'd35, 0, 1, 0);
        run_op("st_0_35",  1'b1, 8'd0,  8'd35, 0, 1, 0);
        run_op("eu_35_0",  1'b0, 8'd35, 8'd0,  0, 1, 0);
        run_op("st_35_0",  1'b1, 8'd35, 8'd0,  0, 1, 0);
        run_op("eu_255_1", 1'b0, 8'd255, 8'd1, 1, 0, 255);
        run_op("st_255_1", 1'b1, 8'd255, 8'd1, 1, 0, 15);
        run_op("eu_7_7",   1'b0, 8'd7,  8'd7,  7, 0, 1);
        run_op("st_7_7",   1'b1, 8'd7,  8'd7,  7, 0, 1);
        run_op("eu_48_18", 1'b0, 8'd48, 8'd18, 6, 0, 5);
        run_op("st_48_18", 1'b1, 8'd48, 8'd18, 6, 0, 7);
        run_op("eu_64_32", 1'b0, 8'd64, 8'd32, 32, 0, 2);
        run_op("st_64_32", 1'b1, 8'd64, 8'd32, 32, 0, 7);

        // START held high, operands disturbed mid-CALC, then back-to-back.
        @(negedge clk);
        mode = 1'b0; a = 8'd12; b = 8'd18; start = 1'b1;
        @(negedge clk);
        a = 8'd200; b = 8'd3;
        cyc = 0; seen = done;
        while (!seen && cyc < 600) begin
            @(negedge clk);
            cyc++;
            seen = done;
        end
        check("held_done_seen", seen, 1);
        check("held_latency", cyc, 3);
        check("held_y", y, 6);
        check("held_iter", iter, 3);
        a = 8'd21; b = 8'd14;
        @(negedge clk);
        check("b2b_idle_busy", busy, 0);
        @(negedge clk);
        start = 1'b0;
        check("b2b_accept_busy", busy, 1);
        cyc = 0; seen = done;
        while (!seen && cyc < 600) begin
            @(negedge clk);
            cyc++;
            seen = done;
        end
        check("b2b_done_seen", seen, 1);
        check("b2b_latency", cyc, 3);
        check("b2b_y", y, 7);
        check("b2b_iter", iter, 3);
        @(negedge clk);

        // Reset at e0+10 during a long Euclid run.
        @(negedge clk);
        mode = 1'b0; a = 8'd255; b = 8'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        check("pre_rst_busy", busy, 1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("mid_rst_y", y, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_error", error, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_iter", iter, 0);
        pulses = 0;
        repeat (300) begin
            @(negedge clk);
            pulses += done ? 1 : 0;
        end
        check("mid_rst_no_done", pulses, 0);
        run_op("after_rst", 1'b1, 8'd48, 8'd18, 6, 0, 7);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
